vec_result_collector: RTL and testbench

- Write-back end of the vector ALU lane interface.
- Each cycle, consumes the per-lane results, bit indices and valid flags produced by the lane wrapper.
- Merges them into a VLEN-bit destination buffer.
- When the wrapper signals done, presents the completed register to the vector register file through a valid/ready write port.
- Sits between the vector ALU wrapper and the vector register file write port.

---
 rtl/vec_pkg.sv | 32 +++
 rtl/vec_slice_merge.sv | 30 +++
 rtl/vec_result_collector.sv | 170 +++++++++++++++++
 tb/tb_vec_result_collector.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared vector-unit definitions: collector state encoding, element/slice width helpers,
// and the register/index geometry also used by the ALU lane wrapper.
package vec_pkg;

    localparam int unsigned VLEN_DEF    = 128;
    localparam int unsigned VLEN_MAX    = 512;
    localparam int unsigned IDX_W       = 10;
    localparam int unsigned LANE_DATA_W = 64;
    localparam int unsigned MAX_LANES   = 4;
    // Slice widths go up to 64, so 7 bits.
    localparam int unsigned SW_W        = 7;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite
    } state_e;

    function automatic int unsigned elem_width(input logic [2:0] vsew);
        return 32'd8 << vsew;
    endfunction

    function automatic logic [SW_W-1:0] slice_width(input logic [2:0] vsew,
                                                    input int unsigned lane_width);
        int unsigned ew;
        int unsigned lw;
        ew = elem_width(vsew);
        lw = 32'd1 << lane_width;
        return SW_W'((ew < lw) ? ew : lw);
    endfunction

endpackage

// File: rtl/vec_slice_merge.sv
// Combinational mask-and-insert of one lane slice into a VLEN-bit vector.
// Bits that would land at or above VLEN fall off the top of the shift and are dropped.
module vec_slice_merge
    import vec_pkg::*;
#(
    parameter int unsigned VLEN = VLEN_DEF
) (
    input  logic [VLEN-1:0]        vec_in,
    input  logic [LANE_DATA_W-1:0] data,
    input  logic [IDX_W-1:0]       idx,
    input  logic [SW_W-1:0]        sw,
    input  logic                   vld,
    output logic [VLEN-1:0]        vec_out,
    output logic [VLEN-1:0]        touched
);

    logic [LANE_DATA_W-1:0] slice_mask;
    logic [VLEN-1:0]        mask_sh;
    logic [VLEN-1:0]        data_sh;

    always_comb begin
        // sw == 64 shifts the one out entirely, and the subtraction then yields all ones.
        slice_mask = (LANE_DATA_W'(1) << sw) - LANE_DATA_W'(1);
        mask_sh    = VLEN'(slice_mask) << idx;
        data_sh    = VLEN'(data & slice_mask) << idx;
        touched    = vld ? mask_sh : '0;
        vec_out    = (vec_in & ~touched) | (data_sh & touched);
    end

endmodule

// File: rtl/vec_result_collector.sv
// Write-back collector: merges per-lane slices into a VLEN-bit buffer and issues one
// register-file write per instruction. Optional byte enables under VEC_COLLECT_BE_EN.
module vec_result_collector
    import vec_pkg::*;
#(
    parameter int unsigned VLEN       = VLEN_DEF,
    parameter int unsigned LANE_WIDTH = 4,
    parameter int unsigned NB_LANES   = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [4:0]             vd_addr,
    input  logic [2:0]             vsew,
    input  logic [LANE_DATA_W-1:0] lane_data0,
    input  logic [LANE_DATA_W-1:0] lane_data1,
    input  logic [LANE_DATA_W-1:0] lane_data2,
    input  logic [LANE_DATA_W-1:0] lane_data3,
    input  logic [IDX_W-1:0]       lane_idx0,
    input  logic [IDX_W-1:0]       lane_idx1,
    input  logic [IDX_W-1:0]       lane_idx2,
    input  logic [IDX_W-1:0]       lane_idx3,
    input  logic                   lane_vld0,
    input  logic                   lane_vld1,
    input  logic                   lane_vld2,
    input  logic                   lane_vld3,
    input  logic                   done_in,
    output logic                   busy,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [4:0]             wr_addr,
    output logic [VLEN-1:0]        wr_data
`ifdef VEC_COLLECT_BE_EN
    ,
    output logic [VLEN/8-1:0]      wr_be
`endif
);

    localparam int unsigned NL = 1 << NB_LANES;
    localparam logic [MAX_LANES-1:0] LANE_EN = MAX_LANES'((1 << NL) - 1);

    state_e            state_q, state_d;
    logic [VLEN-1:0]   buf_q, buf_d;
    logic [4:0]        addr_q, addr_d;
    logic [2:0]        sew_q, sew_d;

    logic [LANE_DATA_W-1:0] l_data [MAX_LANES];
    logic [IDX_W-1:0]       l_idx  [MAX_LANES];
    logic [MAX_LANES-1:0]   l_vld;
    logic [SW_W-1:0]        sw;
    logic [VLEN-1:0]        chain   [MAX_LANES+1];
    logic [VLEN-1:0]        touched [MAX_LANES];

    assign l_data[0] = lane_data0;
    assign l_data[1] = lane_data1;
    assign l_data[2] = lane_data2;
    assign l_data[3] = lane_data3;
    assign l_idx[0]  = lane_idx0;
    assign l_idx[1]  = lane_idx1;
    assign l_idx[2]  = lane_idx2;
    assign l_idx[3]  = lane_idx3;
    // Lanes beyond the instantiated count never merge.
    assign l_vld     = {lane_vld3, lane_vld2, lane_vld1, lane_vld0} & LANE_EN;

    assign sw       = slice_width(sew_q, LANE_WIDTH);
    assign chain[0] = buf_q;

    // Chained in lane order so a higher lane overwrites a lower one on overlap.
    for (genvar k = 0; k < MAX_LANES; k++) begin : g_lane
        vec_slice_merge #(
            .VLEN (VLEN)
        ) u_merge (
            .vec_in  (chain[k]),
            .data    (l_data[k]),
            .idx     (l_idx[k]),
            .sw      (sw),
            .vld     (l_vld[k]),
            .vec_out (chain[k+1]),
            .touched (touched[k])
        );
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        sew_d   = sew_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    buf_d   = '0;
                    addr_d  = vd_addr;
                    sew_d   = vsew;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                buf_d = chain[MAX_LANES];
                if (done_in) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (wr_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            buf_q   <= '0;
            addr_q  <= '0;
            sew_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            sew_q   <= sew_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign wr_valid = (state_q == StWrite);
    assign wr_addr  = addr_q;
    assign wr_data  = buf_q;

`ifdef VEC_COLLECT_BE_EN
    logic [VLEN/8-1:0] be_q, be_d;
    logic [VLEN-1:0]   touched_all;

    always_comb begin
        touched_all = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            touched_all = touched_all | touched[k];
        end
        be_d = be_q;
        if (state_q == StIdle && start) begin
            be_d = '0;
        end else if (state_q == StCollect) begin
            for (int b = 0; b < VLEN / 8; b++) begin
                be_d[b] = be_q[b] | (|touched_all[b*8 +: 8]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            be_q <= '0;
        end else begin
            be_q <= be_d;
        end
    end

    assign wr_be = be_q;
`else
    logic unused_touched;

    always_comb begin
        unused_touched = 1'b0;
        for (int k = 0; k < MAX_LANES; k++) begin
            unused_touched = unused_touched ^ (^touched[k]);
        end
    end
`endif

endmodule

// File: tb/tb_vec_result_collector.sv
// Randomized self-checking bench for vec_result_collector against a bit-level reference model.
module tb_vec_result_collector;

    localparam int VLEN = 128;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic        start    = 1'b0;
    logic [4:0]  vd_addr  = '0;
    logic [2:0]  vsew     = '0;
    logic        done_in  = 1'b0;
    logic        wr_ready = 1'b0;
    logic [63:0] ld [4];
    logic [9:0]  li [4];
    logic        lv [4];
    logic             busy;
    logic             wr_valid;
    logic [4:0]       wr_addr;
    logic [VLEN-1:0]  wr_data;
`ifdef VEC_COLLECT_BE_EN
    logic [VLEN/8-1:0] wr_be;
`endif

    logic [VLEN-1:0]   m_buf;
    logic [VLEN/8-1:0] m_be;
    int                m_sew;
    logic [4:0]        m_addr;
    int                n_vec = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    vec_result_collector #(
        .VLEN       (VLEN),
        .LANE_WIDTH (4),
        .NB_LANES   (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .vd_addr    (vd_addr),
        .vsew       (vsew),
        .lane_data0 (ld[0]),
        .lane_data1 (ld[1]),
        .lane_data2 (ld[2]),
        .lane_data3 (ld[3]),
        .lane_idx0  (li[0]),
        .lane_idx1  (li[1]),
        .lane_idx2  (li[2]),
        .lane_idx3  (li[3]),
        .lane_vld0  (lv[0]),
        .lane_vld1  (lv[1]),
        .lane_vld2  (lv[2]),
        .lane_vld3  (lv[3]),
        .done_in    (done_in),
        .busy       (busy),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
`ifdef VEC_COLLECT_BE_EN
        ,
        .wr_be      (wr_be)
`endif
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < 4; k++) begin
            ld[k] = {$urandom, $urandom};
            li[k] = 10'($urandom_range(0, VLEN + 20));
            lv[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic clr_lanes();
        for (int k = 0; k < 4; k++) begin
            ld[k] = {$urandom, $urandom};
            li[k] = 10'($urandom);
            lv[k] = 1'b0;
        end
    endtask

    task automatic set_lane(input int k, input logic [63:0] d, input int idx);
        ld[k] = d;
        li[k] = 10'(idx);
        lv[k] = 1'b1;
    endtask

    // Lanes applied in ascending order, so a later lane overwrites an earlier one.
    task automatic model_merge();
        int sw;
        int p;
        sw = ((8 << m_sew) < 16) ? (8 << m_sew) : 16;
        for (int k = 0; k < 4; k++) begin
            if (lv[k]) begin
                for (int i = 0; i < sw; i++) begin
                    p = int'(li[k]) + i;
                    if (p < VLEN) begin
                        m_buf[p]   = ld[k][i];
                        m_be[p/8]  = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_write(input string tag);
        check_eq({tag, "_valid"}, 512'(wr_valid), 512'(1));
        check_eq({tag, "_busy"}, 512'(busy), 512'(1));
        check_eq({tag, "_addr"}, 512'(wr_addr), 512'(m_addr));
        check_eq({tag, "_data"}, 512'(wr_data), 512'(m_buf));
`ifdef VEC_COLLECT_BE_EN
        check_eq({tag, "_be"}, 512'(wr_be), 512'(m_be));
`endif
    endtask

    task automatic do_start(input logic [4:0] addr, input int sew);
        start   = 1'b1;
        vd_addr = addr;
        vsew    = 3'(sew);
        rand_lanes();
        done_in = 1'($urandom_range(0, 1));
        step();
        start   = 1'b0;
        done_in = 1'b0;
        vd_addr = 5'($urandom);
        vsew    = 3'($urandom);
        clr_lanes();
        m_buf   = '0;
        m_be    = '0;
        m_sew   = sew;
        m_addr  = addr;
        check_eq("start_busy", 512'(busy), 512'(1));
        check_eq("start_novalid", 512'(wr_valid), 512'(0));
    endtask

    task automatic beat(input bit last);
        done_in = last;
        model_merge();
        step();
        done_in = 1'b0;
        clr_lanes();
        if (last) check_write("write");
        else check_eq("collect_novalid", 512'(wr_valid), 512'(0));
    endtask

    task automatic finish_write(input int hold);
        for (int h = 0; h < hold; h++) begin
            wr_ready = 1'b0;
            start    = 1'b1;
            rand_lanes();
            done_in  = 1'($urandom_range(0, 1));
            step();
            check_write("hold");
        end
        start    = 1'b0;
        done_in  = 1'b0;
        clr_lanes();
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        check_eq("post_novalid", 512'(wr_valid), 512'(0));
        check_eq("post_idle", 512'(busy), 512'(0));
    endtask

    initial begin
        clr_lanes();
        // Reset with garbage on every input.
        resetn = 1'b0;
        start  = 1'b1;
        rand_lanes();
        done_in  = 1'b1;
        wr_ready = 1'b1;
        step();
        step();
        start    = 1'b0;
        done_in  = 1'b0;
        wr_ready = 1'b0;
        clr_lanes();
        check_eq("rst_busy", 512'(busy), 512'(0));
        check_eq("rst_valid", 512'(wr_valid), 512'(0));
        check_eq("rst_data", 512'(wr_data), 512'(0));
        check_eq("rst_addr", 512'(wr_addr), 512'(0));
        resetn = 1'b1;
        step();

        // Byte-wide slices, four beats of four lanes.
        do_start(5'd3, 0);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) set_lane(k, 64'(4 * b + k), 8 * k + 32 * b);
            beat(b == 3);
        end
        check_eq("seq_bytes", 512'(wr_data), 512'(128'h0f0e0d0c0b0a09080706050403020100));
        finish_write(0);

        // 32-bit elements clamp to 16-bit slices; held write with start pulses ignored.
        do_start(5'd7, 2);
        for (int k = 0; k < 4; k++) set_lane(k, {16'($urandom), 32'($urandom), 16'hAAAA}, 16 * k);
        beat(0);
        for (int k = 0; k < 4; k++) set_lane(k, {16'($urandom), 32'($urandom), 16'h5555}, 64 + 16 * k);
        beat(1);
        check_eq("half_words", 512'(wr_data), 512'(128'h5555555555555555aaaaaaaaaaaaaaaa));
        finish_write(5);

        // Same-cycle overlap: lane 3 beats lane 0.
        do_start(5'd1, 0);
        set_lane(0, 64'h11, 0);
        set_lane(3, 64'h33, 0);
        beat(1);
        check_eq("overlap", 512'(wr_data), 512'(128'h33));
        finish_write(0);

        // Slice straddling the top edge is truncated, not wrapped.
        do_start(5'd2, 1);
        set_lane(1, 64'hBEEF, 124);
        beat(1);
        check_eq("top_edge", 512'(wr_data), 512'({4'hF, 124'b0}));
        finish_write(1);

        // Reset mid-collection, then a fresh instruction must see a clear buffer.
        do_start(5'd9, 0);
        rand_lanes();
        beat(0);
        rand_lanes();
        beat(0);
        resetn = 1'b0;
        step();
        check_eq("abort_busy", 512'(busy), 512'(0));
        check_eq("abort_valid", 512'(wr_valid), 512'(0));
        check_eq("abort_data", 512'(wr_data), 512'(0));
        check_eq("abort_addr", 512'(wr_addr), 512'(0));
        resetn = 1'b1;
        step();
        check_eq("abort_stays_idle", 512'(busy), 512'(0));
        do_start(5'd4, 0);
        set_lane(0, 64'hAB, 8);
        beat(1);
        check_eq("after_abort", 512'(wr_data), 512'(128'hAB00));
        finish_write(0);

`ifdef VEC_COLLECT_BE_EN
        do_start(5'd5, 0);
        set_lane(0, 64'h5A, 8);
        beat(1);
        check_eq("be_single", 512'(wr_be), 512'(16'h0002));
        check_eq("be_data", 512'(wr_data), 512'(128'h5A00));
        finish_write(0);
`endif

        // Random instructions.
        for (int n = 0; n < 30; n++) begin
            int nb;
            do_start(5'($urandom), $urandom_range(0, 7));
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                rand_lanes();
                beat(b == nb - 1);
            end
            finish_write($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
